// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between two requesters, with registered RAM ports.
// Define RAM_ARB_CLEAR_EN to build the zero-fill clear engine (CLEAR state, cnt sweep, busy).
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  // Handshake: a requester holds reqN (with we/addr/wdata stable) until gntN is high;
  // the operation is accepted in that cycle and reqN may drop or change afterwards.
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state;
  logic              last;
  logic              tag_v;
  logic              tag_id;
  logic              can_grant;
  logic              pick1;
  logic              any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // On a tie the requester that did not win last time is chosen.
  assign can_grant = !reset && (state == S_IDLE);
  assign pick1     = req1 && (!req0 || !last);
  assign gnt1      = can_grant && pick1;
  assign gnt0      = can_grant && req0 && !pick1;
  assign any_gnt   = gnt0 || gnt1;
  assign win_we    = pick1 ? we1 : we0;
  assign win_addr  = pick1 ? addr1 : addr0;
  assign win_wdata = pick1 ? wdata1 : wdata0;
  assign rdata     = ram_q;

`ifdef RAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] cnt;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign state        = S_IDLE;
  assign busy         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_rdaddress <= '0;
      ram_data      <= '0;
      rvalid0       <= 1'b0;
      rvalid1       <= 1'b0;
      tag_v         <= 1'b0;
      tag_id        <= 1'b0;
      last          <= 1'b1;
`ifdef RAM_ARB_CLEAR_EN
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
`endif
    end else begin
      ram_wren <= 1'b0;
      tag_v    <= 1'b0;
      // Second tag stage lines up with the RAM's registered read data.
      rvalid0  <= tag_v && !tag_id;
      rvalid1  <= tag_v && tag_id;
      if (any_gnt) begin
        last <= pick1;
        if (win_we) begin
          ram_wraddress <= win_addr;
          ram_data      <= win_wdata;
          ram_wren      <= 1'b1;
        end else begin
          ram_rdaddress <= win_addr;
          tag_v         <= 1'b1;
          tag_id        <= pick1;
        end
      end
`ifdef RAM_ARB_CLEAR_EN
      case (state)
        S_IDLE: begin
          if (clear) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          ram_wraddress <= cnt;
          ram_data      <= '0;
          ram_wren      <= 1'b1;
          cnt           <= cnt + 1'b1;
          if (cnt == {ADDR_W{1'b1}}) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter with a behavioural RAM and a reference model.
// Clear-engine scenarios are built only when RAM_ARB_CLEAR_EN is defined.
module tb_ram_port_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, clear;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clear(clear), .busy(busy),
    .ram_wraddress(ram_wraddress), .ram_rdaddress(ram_rdaddress),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Behavioural ram32x4: registered read, old data on same-cycle read/write.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as seen by the requesters, expected read returns per cycle.
  logic [DW-1:0]   model_mem [DEPTH];
  logic [DW+1:0]   exp_q[$];
  logic            mlast;
  int              busy_left;
  int              sweep_idx;
  logic            ew_v;
  logic [AW-1:0]   ew_a;
  logic [DW-1:0]   ew_d;

  always @(negedge clk) begin : model
    logic          eg0, eg1, id, w, nv;
    logic [AW-1:0] a, na;
    logic [DW-1:0] d, nd;
    logic [DW+1:0] e, nxt;
    if (reset) begin
      chk("rst_gnt", {gnt0, gnt1}, 0);
      chk("rst_out", {busy, ram_wren, rvalid0, rvalid1}, 0);
      chk("rst_addr", {ram_wraddress, ram_rdaddress, ram_data}, 0);
      mlast     = 1'b1;
      busy_left = 0;
      sweep_idx = 0;
      ew_v      = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
    end else begin
      chk("busy", busy, busy_left > 0);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (busy_left == 0) begin
        if (req0 && req1) begin
          eg0 = mlast;
          eg1 = !mlast;
        end else begin
          eg0 = req0;
          eg1 = req1;
        end
      end
      chk("gnt", {gnt0, gnt1}, {eg0, eg1});
      e = exp_q.pop_front();
      chk("rvalid", {rvalid0, rvalid1}, e[DW+1:DW]);
      if (e[DW+1] || e[DW]) chk("rdata", rdata, e[DW-1:0]);
      chk("wren", ram_wren, ew_v);
      if (ew_v) chk("wr_port", {ram_wraddress, ram_data}, {ew_a, ew_d});
      nv  = 1'b0;
      na  = '0;
      nd  = '0;
      nxt = '0;
      if (eg0 || eg1) begin
        id    = eg1;
        w     = id ? we1 : we0;
        a     = id ? addr1 : addr0;
        d     = id ? wdata1 : wdata0;
        mlast = id;
        if (w) begin
          model_mem[a] = d;
          nv = 1'b1;
          na = a;
          nd = d;
        end else begin
          nxt = {!id, id, model_mem[a]};
        end
      end
`ifdef RAM_ARB_CLEAR_EN
      if (busy_left > 0) begin
        nv = 1'b1;
        na = AW'(sweep_idx);
        nd = '0;
        sweep_idx++;
        busy_left--;
        if (busy_left == 0) for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
      end else if (clear) begin
        busy_left = DEPTH;
        sweep_idx = 0;
      end
`endif
      ew_v = nv;
      ew_a = na;
      ew_d = nd;
      exp_q.push_back(nxt);
    end
  end

  task automatic issue(input logic id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    int n   = 0;
    if (id) begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end
    while (!got && n < 100) begin
      @(negedge clk);
      got = id ? gnt1 : gnt0;
      n++;
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    chk("issue_grant", got, 1);
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;
    int   nb;
    bit   found;
    reset = 1'b1;
    clear = 1'b0;
    wdata0 = '0;
    wdata1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k]       = '0;
      model_mem[k] = '0;
    end
    // Contention held from reset: requester 0 takes the first tie.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("contend_%0d", i), {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single write then read-back of address 5.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 4'hA;
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1);
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    chk("wr_ram", {ram_wren, ram_wraddress, ram_data}, {1'b1, 5'd5, 4'hA});
    @(posedge clk);
    #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    @(negedge clk);
    chk("rd_gnt1", gnt1, 1);
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    chk("rd_early", {rvalid0, rvalid1}, 0);
    @(negedge clk);
    chk("rd_data", {rvalid0, rvalid1, rdata}, {2'b01, 4'hA});
    @(posedge clk);
    #1;

    // Fill every word with 14-i, then read all back.
    for (int i = 0; i < DEPTH; i++) issue(1'(i % 2), 1'b1, AW'(i), DW'(14 - i));
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'((i + 1) % 2), 1'b0, AW'(i), '0);
      if (i == DEPTH - 1) begin
        @(negedge clk);
        @(negedge clk);
        chk("rd31", {rvalid0, rvalid1, rdata}, {2'b10, 4'hF});
        @(posedge clk);
        #1;
      end
    end

`ifdef RAM_ARB_CLEAR_EN
    // Clear with requester 0 held: grant in the clear cycle, none while busy.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3; clear = 1'b1;
    @(negedge clk);
    chk("clr_gnt_same", gnt0, 1);
    @(posedge clk);
    #1 clear = 1'b0;
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      chk("clr_gnt_blocked", gnt0, 0);
    end
    chk("clr_len", nb, 32);
    chk("clr_resume", gnt0, 1);
    @(posedge clk);
    #1 req0 = 1'b0;
    issue(1'b1, 1'b0, 5'd0, '0);
    issue(1'b0, 1'b0, 5'd17, '0);
    issue(1'b1, 1'b0, 5'd31, '0);
    @(negedge clk);
    @(negedge clk);
    chk("clr_rd31", {rvalid0, rvalid1, rdata}, {2'b01, 4'h0});
    @(posedge clk);
    #1;

    // Refill, then abort a sweep with reset once address 9 has been written.
    for (int i = 0; i < DEPTH; i++) issue(1'(i % 2), 1'b1, AW'(i), DW'(14 - i));
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ram_wren && ram_wraddress == 5'd9) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_seen", found, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_async", {busy, ram_wren, rvalid0, rvalid1}, 0);
    for (int k = 0; k < 10; k++) model_mem[k] = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'(i % 2), 1'b0, AW'(i), '0);
      if (i == 9 || i == 10) begin
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("abort_rd%0d", i), {rvalid0, rvalid1, rdata},
            (i == 9) ? {2'b01, 4'h0} : {2'b10, 4'h4});
        @(posedge clk);
        #1;
      end
    end
`endif

    // Random traffic on a small address window to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      @(posedge clk);
      #1;
      if (!req0 || g0) begin
        req0   = ($urandom_range(3) != 0);
        we0    = 1'($urandom_range(1));
        addr0  = AW'($urandom_range(7));
        wdata0 = DW'($urandom);
      end
      if (!req1 || g1) begin
        req1   = ($urandom_range(3) != 0);
        we1    = 1'($urandom_range(1));
        addr1  = AW'($urandom_range(7));
        wdata1 = DW'($urandom);
      end
`ifdef RAM_ARB_CLEAR_EN
      clear = ($urandom_range(60) == 0);
`endif
    end
    req0  = 1'b0;
    req1  = 1'b0;
    clear = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one 32 x 4 dual-port RAM (`ram32x4`) between two requesters, such as the switch/KEY front end and a sequencer or counter-driven scanner. Each cycle the arbiter accepts at most one read or write, registers it onto the RAM ports, and returns read data with a valid strobe. An optional clear engine sweeps the RAM to zero on command. It sits between the requesters and the RAM, replacing direct RAM wiring in `top`.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width; depth is 2**ADDR_W.
- `DATA_W`, 4: RAM data width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  system clock; also clocks the RAM.
- `reset`  input  1  asynchronous, active-high reset.
- `req0`, `req1`  input  1 each  request from requester 0/1; held until granted.
- `we0`, `we1`  input  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  input  ADDR_W each  target address.
- `wdata0`, `wdata1`  input  DATA_W each  write data.
- `gnt0`, `gnt1`  output  1 each  request accepted this cycle (combinational).
- `rvalid0`, `rvalid1`  output  1 each  read data valid for requester 0/1 (one-cycle pulse).
- `rdata`  output  DATA_W  read data, shared by both requesters and qualified by `rvalid*`.
- `clear`  input  1  start a zero-fill sweep (pulse).
- `busy`  output  1  clear sweep in progress.
- `ram_wraddress`, `ram_rdaddress`  output  ADDR_W  RAM addresses.
- `ram_data`  output  DATA_W  RAM write data.
- `ram_wren`  output  1  RAM write enable.
- `ram_q`  input  DATA_W  RAM read data (registered in RAM, 1-cycle latency).

## Operation
- Arbitration: the `last` register holds the most recently granted requester.
  - One request asserted: it is granted.
  - Both asserted: the requester not equal to `last` is granted.
  - `last` updates on every grant.
- At most one grant per cycle. `gnt*` is 0 whenever `reset` or `busy` is high.
- Granted write: on the next edge, register `ram_wraddress`/`ram_data` from the winner and set `ram_wren` = 1 for one cycle.
- Granted read: on the next edge, register `ram_rdaddress` and a tag {valid, id}. The tag is then delayed one more stage to align with `ram_q`.
- `rvalid<id>` = delayed tag; `rdata` = `ram_q`, passed through. `rvalid` of the non-tagged requester stays 0.
- Read/write to the same address in the same RAM cycle: the RAM returns old data. There is no forwarding.
- States: IDLE and CLEAR.
  - IDLE -> CLEAR: `clear` sampled high while in IDLE. A grant in the same cycle still completes; the sweep begins the next cycle.
  - CLEAR: writes 0 to address `cnt`, `cnt` = 0..2**ADDR_W-1, one per cycle, with `ram_wren` = 1.
  - CLEAR -> IDLE: after the write to the last address issues.
  - `clear` asserted during CLEAR is ignored.
- Reads already in flight when CLEAR begins still complete with `rvalid`.
- Reset mid-sweep aborts the sweep. There is no resume.

## Timing
- Reset values:
  - `ram_wren`, `busy`, `rvalid0`, `rvalid1` = 0.
  - `ram_wraddress`, `ram_rdaddress`, `ram_data` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - State = IDLE, `cnt` = 0.
- Write: grant in cycle N -> `ram_wren` high in cycle N+1 -> RAM updated at the end of N+1.
- Read: grant in cycle N -> address on the RAM in N+1 -> `rvalid`/`rdata` in cycle N+2 (latency 2).
- Throughput: one operation per cycle with back-to-back grants allowed. Under continuous dual request, grants strictly alternate.
- Clear: `clear` high in cycle N -> `busy` high in cycles N+1 .. N+2**ADDR_W, writing address k in cycle N+1+k. `busy` is low and grants resume in N+2**ADDR_W+1.
- `cnt` wraps to 0 when the sweep ends.

## Configuration
- Macro `RAM_ARB_CLEAR_EN`.
- Defined: the clear engine and CLEAR state are compiled in, as described above.
- Undefined:
  - `clear` is ignored and `busy` is tied to 0.
  - There is no `cnt` register; the state is fixed at IDLE.
  - All other behaviour is unchanged.

## Test plan
- Reset, then write: `req0`=1, `we0`=1, `addr0`=5, `wdata0`=0xA -> `gnt0`=1 the same cycle; next cycle `ram_wren`=1, `ram_wraddress`=5, `ram_data`=0xA.
- Read back: `req1`=1, `we1`=0, `addr1`=5 -> `rvalid1`=1 with `rdata`=0xA exactly 2 cycles after `gnt1`; `rvalid0` stays 0.
- Contention: `req0` and `req1` both held for 6 cycles from reset -> grants in order 0,1,0,1,0,1; no cycle has both `gnt*` high.
- Fill 32 words with `addr`=i, `wdata`=14-i (mod 16), then read all 32 -> each `rdata` equals the written value; address 31 yields 0xF.
- Clear (`RAM_ARB_CLEAR_EN` defined): after the fill, pulse `clear` with `req0` held -> `busy` high for exactly 32 cycles with `gnt0`=0 throughout; a subsequent read of any address returns 0.
- Reset asserted 10 cycles into a sweep -> `busy`, `ram_wren`, `rvalid*` go to 0 immediately (asynchronously); addresses 0..9 read 0 and addresses 10..31 keep their old data.
